// File: rtl/drive_sequencer_if.sv
// rtl/drive_sequencer_if.sv - drive command valid/ready handshake bundle
interface drive_sequencer_if;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/drive_sequencer.sv
// rtl/drive_sequencer.sv - maps drive commands to ramped wheel duties with dwell and estop
module drive_sequencer #(
    parameter int CLK_DIV   = 500,
    parameter int RAMP_STEP = 8,
    parameter int FAST_DUTY = 200,
    parameter int SLOW_DUTY = 100,
    parameter int MIN_DWELL = 25
) (
    input  logic               clk,
    input  logic               reset,
    drive_sequencer_if.slave   cmd_if,
    input  logic               estop,
    output logic [7:0]         left_duty,
    output logic [7:0]         right_duty,
    output logic [2:0]         active_cmd,
    output logic               ramping
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, BRAKE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [2:0]      active_q, active_d;
    logic [7:0]      ltgt_q, ltgt_d, rtgt_q, rtgt_d;
    logic [7:0]      lduty_q, lduty_d, rduty_q, rduty_d;
    logic            ramping_q, ramping_d;
    logic            tick, is_stop, ready, xfer;
    logic [15:0]     table_tgt;

    // One ramp step toward tgt; 9-bit math so the step can never wrap or overshoot.
    function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] diff;
        logic [8:0] stepv;
        diff  = (tgt >= cur) ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        stepv = (diff > 9'(RAMP_STEP)) ? 9'(RAMP_STEP) : diff;
        return (tgt >= cur) ? 8'({1'b0, cur} + stepv) : 8'({1'b0, cur} - stepv);
    endfunction

    always_comb begin
        case (cmd_if.cmd)
            3'd1:    table_tgt = {8'd0, 8'(FAST_DUTY)};
            3'd2:    table_tgt = {8'(SLOW_DUTY), 8'(FAST_DUTY)};
            3'd3:    table_tgt = {8'(FAST_DUTY), 8'(FAST_DUTY)};
            3'd4:    table_tgt = {8'(FAST_DUTY), 8'(SLOW_DUTY)};
            3'd5:    table_tgt = {8'(FAST_DUTY), 8'd0};
            default: table_tgt = 16'd0;
        endcase
    end

    assign tick    = (tick_cnt_q == TW'(CLK_DIV - 1));
    assign is_stop = (cmd_if.cmd == 3'd0) || (cmd_if.cmd > 3'd5);

    always_comb begin
        ready = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            HOLD:    ready = (dwell_q == '0) || is_stop;
            default: ready = 1'b0;
        endcase
        if (reset) ready = 1'b0;
    end

    assign cmd_if.cmd_ready = ready;
    assign xfer             = cmd_if.cmd_valid && ready;

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        state_d    = state_q;
        dwell_d    = dwell_q;
        active_d   = active_q;
        ltgt_d     = ltgt_q;
        rtgt_d     = rtgt_q;
        lduty_d    = lduty_q;
        rduty_d    = rduty_q;
        if (estop) begin
            state_d  = BRAKE;
            dwell_d  = '0;
            active_d = 3'd0;
            ltgt_d   = 8'd0;
            rtgt_d   = 8'd0;
            lduty_d  = 8'd0;
            rduty_d  = 8'd0;
        end else if (state_q == BRAKE) begin
            state_d = IDLE;
        end else begin
            // The tick uses the old targets; a same-edge transfer only takes effect next tick.
            if (tick) begin
                lduty_d = ramp_to(lduty_q, ltgt_q);
                rduty_d = ramp_to(rduty_q, rtgt_q);
                if (state_q == HOLD && dwell_q != '0) dwell_d = dwell_q - 1'b1;
            end
            if (xfer) begin
                if (is_stop) begin
                    state_d  = IDLE;
                    active_d = 3'd0;
                    ltgt_d   = 8'd0;
                    rtgt_d   = 8'd0;
                end else begin
                    state_d  = HOLD;
                    dwell_d  = DW'(MIN_DWELL);
                    active_d = cmd_if.cmd;
                    ltgt_d   = table_tgt[15:8];
                    rtgt_d   = table_tgt[7:0];
                end
            end
        end
        ramping_d = (lduty_d != ltgt_d) || (rduty_d != rtgt_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            dwell_q    <= '0;
            active_q   <= 3'd0;
            ltgt_q     <= 8'd0;
            rtgt_q     <= 8'd0;
            lduty_q    <= 8'd0;
            rduty_q    <= 8'd0;
            ramping_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            dwell_q    <= dwell_d;
            active_q   <= active_d;
            ltgt_q     <= ltgt_d;
            rtgt_q     <= rtgt_d;
            lduty_q    <= lduty_d;
            rduty_q    <= rduty_d;
            ramping_q  <= ramping_d;
        end
    end

    assign left_duty  = lduty_q;
    assign right_duty = rduty_q;
    assign active_cmd = active_q;
    assign ramping    = ramping_q;
endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Sits between the drive-command decoder and the motor PWM generators.
- Accepts 3-bit drive commands through a valid/ready handshake and maps each command to left/right wheel duty targets.
- Ramps the actual duties toward those targets at a fixed rate and enforces a minimum dwell time between steering changes.
- An emergency-stop input overrides everything else.

Parameters:
- CLK_DIV, 500: clk cycles per ramp tick (≥2).
- RAMP_STEP, 8: maximum duty change per tick (1..255).
- FAST_DUTY, 200: duty used by fast wheels (8-bit).
- SLOW_DUTY, 100: duty used by slow wheels (8-bit, ≤FAST_DUTY).
- MIN_DWELL, 25: ticks a steering command is held before a new non-Stop command is accepted.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cmd  input  3  0 Stop, 1 Fast_left, 2 Left, 3 Straight, 4 Right, 5 Fast_right, 6/7 treated as Stop
- cmd_valid  input  1  cmd is presented
- cmd_ready  output  1  sequencer accepts cmd this cycle
- estop  input  1  level emergency stop, highest priority
- left_duty  output  8  left wheel PWM duty
- right_duty  output  8  right wheel PWM duty
- active_cmd  output  3  last accepted command (Stop after estop)
- ramping  output  1  a duty differs from its target

Behaviour:
- Reset (async): left_duty=0, right_duty=0, active_cmd=0, ramping=0, cmd_ready=0, tick counter=0, dwell counter=0, state=IDLE.
- Tick: a free-running counter from 0 to CLK_DIV-1 asserts an internal tick for 1 cycle at the wrap. It is not reset by commands.
- Target table (left,right):
  - Stop (0,0)
  - Fast_left (0,FAST)
  - Left (SLOW,FAST)
  - Straight (FAST,FAST)
  - Right (FAST,SLOW)
  - Fast_right (FAST,0)
- Handshake: a transfer occurs when cmd_valid&cmd_ready at a rising edge. active_cmd and targets update on the next edge. cmd_ready is combinational from state and cmd:
  - 1 in IDLE.
  - In HOLD, 1 only when the dwell counter has expired or cmd decodes to Stop.
  - 0 in BRAKE.
- States:
  - IDLE: targets = Stop. On transfer of a non-Stop cmd → HOLD with dwell counter = MIN_DWELL. A Stop transfer stays in IDLE.
  - HOLD: dwell counter decrements on each tick, saturating at 0. On a Stop transfer → IDLE. On a non-Stop transfer (counter=0) → HOLD with the counter reloaded. Re-accepting the same cmd also reloads the counter.
  - BRAKE: entered from any state on the first edge where estop=1. Duties are forced to 0 on that edge, with no ramp; active_cmd=0 and targets=Stop. Stays in BRAKE while estop=1. When estop=0 → IDLE. Commands are ignored while in BRAKE.
- Ramp (IDLE/HOLD only): on each tick, each duty moves toward its target by min(RAMP_STEP, |target-duty|). Use 9-bit intermediates; the result never overshoots and never wraps.
- ramping = (left_duty≠left target)|(right_duty≠right target), registered with the duties.
- Simultaneous events:
  - estop beats transfer and tick.
  - A transfer and a tick on the same edge: the tick ramps toward the OLD target, and the new target applies from the next tick.
- Reset mid-ramp: outputs go to 0 immediately. The tick counter restarts at 0.

Test Plan:
- Use CLK_DIV=4, RAMP_STEP=8, FAST=200, SLOW=100, MIN_DWELL=3 for all scenarios.
- Reset, then transfer cmd=3: after 25 ticks left=right=200 with 8/tick increments. ramping stays 1 until the 25th tick, then drops to 0.
- In HOLD (Straight), present cmd=2 immediately: cmd_ready=0 for 3 ticks, then the transfer happens. Left ramps 200→100 in 13 ticks (12×8 then 4); right stays at 200.
- During HOLD, cmd=0 with dwell counter nonzero: accepted the same cycle, state=IDLE, both duties ramp to 0.
- Straight at 200/200, assert estop for 1 cycle: next edge gives duties 0/0 and active_cmd=0. cmd_valid is ignored while in BRAKE. After estop=0 the state is IDLE and cmd_ready=1.
- Transfer cmd=6: treated as Stop, active_cmd=6 is never output (active_cmd=0), duties stay 0.
- Assert reset mid-ramp (left=96): outputs are 0 asynchronously without waiting for a clk edge. After release the first tick occurs 4 cycles later.
